// File: rtl/df_deadlock_pkg.sv
// Shared types for the dataflow deadlock watchdog: FSM states and deadlock_kind codes.
package df_deadlock_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WATCH    = 2'd1,
    DEADLOCK = 2'd2,
    DONE     = 2'd3
  } state_e;

  localparam logic [1:0] KIND_NONE  = 2'd0;
  localparam logic [1:0] KIND_IN    = 2'd1;
  localparam logic [1:0] KIND_OUT   = 2'd2;
  localparam logic [1:0] KIND_MIXED = 2'd3;

endpackage

// File: rtl/df_proc_activity_tracker.sv
// One process's active bit: set by its start handshake, cleared by its done handshake.
module df_proc_activity_tracker (
  input  logic clock,
  input  logic reset,
  input  logic proc_start,
  input  logic proc_done,
  output logic active
);

  // A start coinciding with a done means a new invocation began, so start wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      active <= 1'b0;
    else if (proc_start)
      active <= 1'b1;
    else if (proc_done)
      active <= 1'b0;
  end

endmodule

// File: rtl/df_deadlock_detector.sv
// Dataflow deadlock watchdog: flags when all active processes stay stalled for TIMEOUT cycles.
// Optional stall_max watermark register enabled by DF_DEADLOCK_WATERMARK_EN.
//
// state    | meaning
// IDLE     | no process active, nothing to watch
// WATCH    | processes active, counting consecutive all-stalled cycles
// DEADLOCK | deadlock declared; terminal until reset, outputs hold
// DONE     | finish seen; terminal, detection stopped, stall_run frozen
module df_deadlock_detector
  import df_deadlock_pkg::*;
#(
  parameter int NUM_PROC = 2,
  parameter int TIMEOUT  = 1024,
  parameter int CNT_W    = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_PROC-1:0] proc_start,
  input  logic [NUM_PROC-1:0] proc_done,
  input  logic [NUM_PROC-1:0] proc_cin_stall,
  input  logic [NUM_PROC-1:0] proc_cout_stall,
  input  logic                region_idle,
  input  logic                finish,
  output logic                find_df_deadlock,
  output logic [NUM_PROC-1:0] deadlock_mask,
  output logic [1:0]          deadlock_kind,
  output logic [CNT_W-1:0]    stall_run,
  output logic [CNT_W-1:0]    stall_max
);

  // Threshold compare is done at >=32 bits so a narrow counter never aliases TIMEOUT-1.
  localparam int              CMP_W  = (CNT_W > 32) ? CNT_W : 32;
  localparam logic [CMP_W-1:0] THRESH = CMP_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    run_q, run_d;
  logic [NUM_PROC-1:0] mask_q, mask_d;
  logic [1:0]          kind_q, kind_d;
  logic [NUM_PROC-1:0] active;
  logic [NUM_PROC-1:0] stalled;
  logic [NUM_PROC-1:0] cin_only;
  logic [NUM_PROC-1:0] cout_only;
  logic                all_stalled;
  logic                progress;
  logic                at_thresh;

  for (genvar i = 0; i < NUM_PROC; i++) begin : g_track
    df_proc_activity_tracker u_track (
      .clock      (clock),
      .reset      (reset),
      .proc_start (proc_start[i]),
      .proc_done  (proc_done[i]),
      .active     (active[i])
    );
  end

  assign stalled     = proc_cin_stall | proc_cout_stall;
  assign cin_only    = proc_cin_stall & ~proc_cout_stall;
  assign cout_only   = proc_cout_stall & ~proc_cin_stall;
  assign all_stalled = (|active) & ~(|(active & ~stalled)) & ~region_idle;
  assign progress    = (|proc_start) | (|proc_done) | (|(active & ~stalled));
  assign at_thresh   = (CMP_W'(run_q) == THRESH);

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    mask_d  = mask_q;
    kind_d  = kind_q;
    case (state_q)
      IDLE: begin
        if (finish)
          state_d = DONE;
        else if (|active)
          state_d = WATCH;
      end
      WATCH: begin
        if (finish) begin
          state_d = DONE;
        end else if (~(|active)) begin
          state_d = IDLE;
          run_d   = '0;
        end else if (all_stalled && !progress) begin
          run_d = (&run_q) ? run_q : run_q + CNT_W'(1);
          if (at_thresh) begin
            state_d = DEADLOCK;
            mask_d  = active;
            if ((active & ~cin_only) == '0)
              kind_d = KIND_IN;
            else if ((active & ~cout_only) == '0)
              kind_d = KIND_OUT;
            else
              kind_d = KIND_MIXED;
          end
        end else begin
          run_d = '0;
        end
      end
      DEADLOCK: ;
      DONE:     ;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      run_q   <= '0;
      mask_q  <= '0;
      kind_q  <= KIND_NONE;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      mask_q  <= mask_d;
      kind_q  <= kind_d;
    end
  end

  assign find_df_deadlock = (state_q == DEADLOCK);
  assign deadlock_mask    = mask_q;
  assign deadlock_kind    = kind_q;
  assign stall_run        = run_q;

`ifdef DF_DEADLOCK_WATERMARK_EN
  logic [CNT_W-1:0] max_q;

  // Tracks the registered run, so it lags stall_run by one cycle; frozen once terminal.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      max_q <= '0;
    else if (((state_q == IDLE) || (state_q == WATCH)) && (run_q > max_q))
      max_q <= run_q;
  end

  assign stall_max = max_q;
`else
  assign stall_max = '0;
`endif

endmodule

// File: tb/tb_df_deadlock_detector.sv
// Directed self-checking bench for df_deadlock_detector (TIMEOUT=16, plus a 3-bit counter instance).
module tb_df_deadlock_detector;

  localparam int NP = 2;
  localparam int TO = 16;
  localparam int CW = 32;

  logic          clock;
  logic          reset;
  logic [NP-1:0] proc_start;
  logic [NP-1:0] proc_done;
  logic [NP-1:0] proc_cin_stall;
  logic [NP-1:0] proc_cout_stall;
  logic          region_idle;
  logic          finish;
  logic          find_df_deadlock;
  logic [NP-1:0] deadlock_mask;
  logic [1:0]    deadlock_kind;
  logic [CW-1:0] stall_run;
  logic [CW-1:0] stall_max;

  logic          sat_find;
  logic [NP-1:0] sat_mask;
  logic [1:0]    sat_kind;
  logic [2:0]    sat_run;
  logic [2:0]    sat_max;

  int checks = 0;
  int errors = 0;

`ifdef DF_DEADLOCK_WATERMARK_EN
  localparam bit WM = 1'b1;
`else
  localparam bit WM = 1'b0;
`endif

  df_deadlock_detector #(.NUM_PROC(NP), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clock            (clock),
    .reset            (reset),
    .proc_start       (proc_start),
    .proc_done        (proc_done),
    .proc_cin_stall   (proc_cin_stall),
    .proc_cout_stall  (proc_cout_stall),
    .region_idle      (region_idle),
    .finish           (finish),
    .find_df_deadlock (find_df_deadlock),
    .deadlock_mask    (deadlock_mask),
    .deadlock_kind    (deadlock_kind),
    .stall_run        (stall_run),
    .stall_max        (stall_max)
  );

  df_deadlock_detector #(.NUM_PROC(NP), .TIMEOUT(TO), .CNT_W(3)) dut_sat (
    .clock            (clock),
    .reset            (reset),
    .proc_start       (proc_start),
    .proc_done        (proc_done),
    .proc_cin_stall   (proc_cin_stall),
    .proc_cout_stall  (proc_cout_stall),
    .region_idle      (region_idle),
    .finish           (finish),
    .find_df_deadlock (sat_find),
    .deadlock_mask    (sat_mask),
    .deadlock_kind    (sat_kind),
    .stall_run        (sat_run),
    .stall_max        (sat_max)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    proc_start      = '0;
    proc_done       = '0;
    proc_cin_stall  = '0;
    proc_cout_stall = '0;
    region_idle     = 1'b0;
    finish          = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Start pulse then one cycle for IDLE->WATCH; counting starts on the following edge.
  task automatic start_procs(input logic [NP-1:0] s);
    proc_start = s;
    tick();
    proc_start = '0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({find_df_deadlock, deadlock_mask, deadlock_kind, stall_run, stall_max} !== '0) begin
      errors++;
      $display("FAIL reset_state: got find=%0b mask=%0h kind=%0d run=%0d max=%0d required all 0",
               find_df_deadlock, deadlock_mask, deadlock_kind, stall_run, stall_max);
    end
  endtask

  task automatic test_basic();
    int bad_k;
    do_reset();
    proc_cin_stall = 2'b01;
    start_procs(2'b01);
    bad_k = -1;
    for (int k = 1; k < TO; k++) begin
      tick();
      if (find_df_deadlock !== 1'b0 || stall_run !== CW'(k)) bad_k = k;
    end
    checks++;
    if (bad_k != -1) begin
      errors++;
      $display("FAIL basic_count: mismatch at cycle %0d (find=%0b run=%0d) required find=0 run=%0d",
               bad_k, find_df_deadlock, stall_run, bad_k);
    end
    tick();
    checks++;
    if ({find_df_deadlock, deadlock_mask, deadlock_kind} !== {1'b1, 2'b01, 2'd1}) begin
      errors++;
      $display("FAIL basic_declare: got find=%0b mask=%0b kind=%0d required 1/01/1",
               find_df_deadlock, deadlock_mask, deadlock_kind);
    end
  endtask

  task automatic test_reset_mid_deadlock();
    int n;
    proc_cin_stall = 2'b01;
    proc_done = 2'b01;
    proc_start = 2'b10;
    tick();
    proc_done = '0;
    proc_start = '0;
    tick();
    checks++;
    if ({find_df_deadlock, deadlock_mask, deadlock_kind} !== {1'b1, 2'b01, 2'd1}) begin
      errors++;
      $display("FAIL deadlock_hold: got find=%0b mask=%0b kind=%0d required 1/01/1",
               find_df_deadlock, deadlock_mask, deadlock_kind);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({find_df_deadlock, deadlock_mask, deadlock_kind, stall_run, stall_max} !== '0) begin
      errors++;
      $display("FAIL async_reset: got find=%0b mask=%0h kind=%0d run=%0d max=%0d required all 0",
               find_df_deadlock, deadlock_mask, deadlock_kind, stall_run, stall_max);
    end
    tick();
    reset = 1'b0;
    proc_start = 2'b01;
    n = 0;
    do begin
      tick();
      proc_start = '0;
      n++;
    end while (!find_df_deadlock && n < 60);
    checks++;
    if (n != TO + 2 || deadlock_mask !== 2'b01) begin
      errors++;
      $display("FAIL redetect: got find after %0d cycles mask=%0b required %0d cycles mask=01",
               n, deadlock_mask, TO + 2);
    end
  endtask

  task automatic test_kinds();
    logic [NP-1:0] t_start [4] = '{2'b11, 2'b11, 2'b01, 2'b11};
    logic [NP-1:0] t_cin   [4] = '{2'b10, 2'b00, 2'b01, 2'b11};
    logic [NP-1:0] t_cout  [4] = '{2'b01, 2'b11, 2'b01, 2'b00};
    logic [1:0]    t_kind  [4] = '{2'd3, 2'd2, 2'd3, 2'd1};
    for (int v = 0; v < 4; v++) begin
      do_reset();
      proc_cin_stall  = t_cin[v];
      proc_cout_stall = t_cout[v];
      start_procs(t_start[v]);
      repeat (TO - 1) tick();
      checks++;
      if (find_df_deadlock !== 1'b0) begin
        errors++;
        $display("FAIL kind_early_%0d: got find=%0b one cycle before threshold required 0",
                 v, find_df_deadlock);
      end
      tick();
      checks++;
      if ({find_df_deadlock, deadlock_mask, deadlock_kind} !== {1'b1, t_start[v], t_kind[v]}) begin
        errors++;
        $display("FAIL kind_%0d: got find=%0b mask=%0b kind=%0d required 1/%0b/%0d",
                 v, find_df_deadlock, deadlock_mask, deadlock_kind, t_start[v], t_kind[v]);
      end
    end
  endtask

  task automatic test_watermark_progress();
    do_reset();
    proc_cin_stall = 2'b11;
    start_procs(2'b11);
    repeat (TO - 1) tick();
    checks++;
    if (stall_run !== CW'(TO - 1)) begin
      errors++;
      $display("FAIL wm_run_pre: got run=%0d required %0d", stall_run, TO - 1);
    end
    proc_done = 2'b10;
    tick();
    proc_done = '0;
    checks++;
    if ({find_df_deadlock, stall_run} !== {1'b0, CW'(0)}) begin
      errors++;
      $display("FAIL wm_progress_reset: got find=%0b run=%0d required 0/0",
               find_df_deadlock, stall_run);
    end
    checks++;
    if (stall_max !== (WM ? CW'(TO - 1) : CW'(0))) begin
      errors++;
      $display("FAIL wm_max: got max=%0d required %0d", stall_max, WM ? TO - 1 : 0);
    end
    repeat (3) tick();
    checks++;
    if (stall_run !== CW'(3) || stall_max !== (WM ? CW'(TO - 1) : CW'(0))) begin
      errors++;
      $display("FAIL wm_hold: got run=%0d max=%0d required 3/%0d",
               stall_run, stall_max, WM ? TO - 1 : 0);
    end
  endtask

  task automatic test_finish_threshold();
    do_reset();
    proc_cin_stall = 2'b01;
    start_procs(2'b01);
    repeat (TO - 1) tick();
    finish = 1'b1;
    tick();
    checks++;
    if ({find_df_deadlock, stall_run} !== {1'b0, CW'(TO - 1)}) begin
      errors++;
      $display("FAIL finish_threshold: got find=%0b run=%0d required 0/%0d",
               find_df_deadlock, stall_run, TO - 1);
    end
    finish = 1'b0;
    proc_start = 2'b10;
    tick();
    proc_start = '0;
    proc_cin_stall = 2'b11;
    repeat (2 * TO) tick();
    checks++;
    if ({find_df_deadlock, stall_run} !== {1'b0, CW'(TO - 1)}) begin
      errors++;
      $display("FAIL done_terminal: got find=%0b run=%0d required 0/%0d",
               find_df_deadlock, stall_run, TO - 1);
    end
  endtask

  task automatic test_region_idle();
    do_reset();
    region_idle     = 1'b1;
    proc_cin_stall  = 2'b11;
    proc_cout_stall = 2'b11;
    repeat (10) tick();
    checks++;
    if ({find_df_deadlock, stall_run} !== {1'b0, CW'(0)}) begin
      errors++;
      $display("FAIL idle_no_active: got find=%0b run=%0d required 0/0", find_df_deadlock, stall_run);
    end
    start_procs(2'b11);
    repeat (2 * TO) tick();
    checks++;
    if ({find_df_deadlock, stall_run} !== {1'b0, CW'(0)}) begin
      errors++;
      $display("FAIL idle_region_mask: got find=%0b run=%0d required 0/0", find_df_deadlock, stall_run);
    end
    region_idle = 1'b0;
    tick();
    checks++;
    if (stall_run !== CW'(1)) begin
      errors++;
      $display("FAIL idle_release: got run=%0d required 1", stall_run);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    proc_cin_stall = 2'b01;
    start_procs(2'b01);
    repeat (TO + 4) tick();
    checks++;
    if ({sat_find, sat_mask, sat_kind, sat_run} !== {1'b0, 2'b00, 2'd0, 3'd7}) begin
      errors++;
      $display("FAIL saturate: got find=%0b mask=%0b kind=%0d run=%0d required 0/00/0/7",
               sat_find, sat_mask, sat_kind, sat_run);
    end
    checks++;
    if (sat_max !== (WM ? 3'd7 : 3'd0)) begin
      errors++;
      $display("FAIL saturate_max: got max=%0d required %0d", sat_max, WM ? 7 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_mid_deadlock();
    test_kinds();
    test_watermark_progress();
    test_finish_threshold();
    test_region_idle();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
